// File: rtl/tmds_pkg.sv
// Purpose: shared types and constants for the TMDS period scheduler and its downstream word mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tmds_pkg;

    // Per-cycle HDMI period classification.
    typedef enum logic [1:0] {
        PER_CTRL     = 2'd0,
        PER_PREAMBLE = 2'd1,
        PER_GUARD    = 2'd2,
        PER_ACTIVE   = 2'd3
    } period_t;

    // Default 640x480@60 raster.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Control-period sub-phase lengths ahead of each active line.
    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;

    // Video preamble CTL codes: {CTL1,CTL0} on ch1, {CTL3,CTL2} on ch2.
    localparam logic [1:0] VID_PRE_CH1 = 2'b01;
    localparam logic [1:0] VID_PRE_CH2 = 2'b00;

    // Video guard-band words substituted for encoder output.
    localparam logic [9:0] VID_GB_CH0 = 10'b1011001100;
    localparam logic [9:0] VID_GB_CH1 = 10'b0100110011;
    localparam logic [9:0] VID_GB_CH2 = 10'b1011001100;

    // TMDS control symbols indexed by {c1,c0}.
    localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Purpose: horizontal/vertical raster counters; exposes current and next position plus next-line-active flag.
// Latency: counters update every enabled clk; h_nxt/v_nxt/nxt_line_act are combinational from the counters.
// Backpressure: none; en=0 synchronously returns both counters to 0.
module hdmi_timing_counter
    import tmds_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP,
    parameter int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        en,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic [11:0] h_nxt,
    output logic [11:0] v_nxt,
    output logic        nxt_line_act
);

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);

    logic        h_wrap;
    logic [11:0] v_succ;

    always_comb begin
        h_wrap       = (h_cnt == H_LAST);
        // Line number that follows the current one, wrapping at frame end.
        v_succ       = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        nxt_line_act = (v_succ < V_ACT);
        h_nxt        = 12'd0;
        v_nxt        = 12'd0;
        if (en) begin
            h_nxt = h_wrap ? 12'd0 : h_cnt + 12'd1;
            v_nxt = h_wrap ? v_succ : v_cnt;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt <= 12'd0;
            v_cnt <= 12'd0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

endmodule

// File: rtl/tmds_period_scheduler.sv
// Purpose: raster timing plus HDMI preamble/guard scheduling for three TMDS encoders; pix_req leads de by one cycle.
// Latency: all outputs registered, one clk behind the counters that produced them.
// Backpressure: none; en=0 forces reset values on the next edge and restarts from (0,0).
module tmds_period_scheduler
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int HDMI_MODE = 1
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic        en,
    output logic        de,
    output logic [1:0]  ch0_ctrl,
    output logic [1:0]  ch1_ctrl,
    output logic [1:0]  ch2_ctrl,
    output logic        guard,
    output logic        pix_req,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] HA    = 12'(H_ACTIVE);
    localparam logic [11:0] VA    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_B  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_E  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_B  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_E  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] PRE_B = 12'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [11:0] GRD_B = 12'(H_TOTAL - GUARD_LEN);
    localparam logic        HS_ON = 1'(HSYNC_POL);
    localparam logic        VS_ON = 1'(VSYNC_POL);
    localparam logic [1:0]  CH0_IDLE = {~VS_ON, ~HS_ON};

    logic [11:0] h_cnt, v_cnt, h_nxt, v_nxt;
    logic        nxt_line_act;

    hdmi_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .V_ACTIVE(V_ACTIVE)
    ) u_cnt (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .en          (en),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_nxt       (h_nxt),
        .v_nxt       (v_nxt),
        .nxt_line_act(nxt_line_act)
    );

    period_t    period;
    logic       hs_on, vs_on;
    logic       d_de, d_guard, d_pix;
    logic [1:0] d_ch0, d_ch1, d_ch2;

    always_comb begin
        period  = PER_CTRL;
        hs_on   = (h_cnt >= HS_B) && (h_cnt <= HS_E);
        vs_on   = (v_cnt >= VS_B) && (v_cnt <= VS_E);
        d_ch0   = {vs_on ? VS_ON : ~VS_ON, hs_on ? HS_ON : ~HS_ON};
        d_ch1   = 2'b00;
        d_ch2   = 2'b00;
        d_de    = 1'b0;
        d_guard = 1'b0;
        // pix_req looks at where the counters go next, so it lands one
        // cycle ahead of the de produced from that position.
        d_pix   = (h_nxt < HA) && (v_nxt < VA);

        if ((h_cnt < HA) && (v_cnt < VA)) begin
            period = PER_ACTIVE;
        end else if ((HDMI_MODE != 0) && nxt_line_act && (h_cnt >= PRE_B)) begin
            // Tail of a line whose successor carries video.
            period = (h_cnt >= GRD_B) ? PER_GUARD : PER_PREAMBLE;
        end

        case (period)
            PER_ACTIVE: begin
                d_de  = 1'b1;
                d_ch0 = 2'b00;
            end
            PER_PREAMBLE: begin
                d_ch1 = VID_PRE_CH1;
                d_ch2 = VID_PRE_CH2;
            end
            PER_GUARD: begin
                d_ch1   = VID_PRE_CH1;
                d_ch2   = VID_PRE_CH2;
                d_guard = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            de          <= 1'b0;
            ch0_ctrl    <= CH0_IDLE;
            ch1_ctrl    <= 2'b00;
            ch2_ctrl    <= 2'b00;
            guard       <= 1'b0;
            pix_req     <= 1'b0;
            hcount      <= 12'd0;
            vcount      <= 12'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (!en) begin
            de          <= 1'b0;
            ch0_ctrl    <= CH0_IDLE;
            ch1_ctrl    <= 2'b00;
            ch2_ctrl    <= 2'b00;
            guard       <= 1'b0;
            pix_req     <= 1'b0;
            hcount      <= 12'd0;
            vcount      <= 12'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            de          <= d_de;
            ch0_ctrl    <= d_ch0;
            ch1_ctrl    <= d_ch1;
            ch2_ctrl    <= d_ch2;
            guard       <= d_guard;
            pix_req     <= d_pix;
            hcount      <= h_cnt;
            vcount      <= v_cnt;
            frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            line_start  <= (h_cnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_tmds_period_scheduler.sv
module tb_tmds_period_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    always #5 clk = ~clk;

    // Default 640x480 HDMI instance.
    logic        d_de, d_guard, d_pix, d_fs, d_ls;
    logic [1:0]  d_ch0, d_ch1, d_ch2;
    logic [11:0] d_h, d_v;
    // Small-raster HDMI instance: 16+4+6+12=38 by 6+2+2+3=13.
    logic        s_de, s_guard, s_pix, s_fs, s_ls;
    logic [1:0]  s_ch0, s_ch1, s_ch2;
    logic [11:0] s_h, s_v;
    // Same small raster, plain DVI.
    logic        p_de, p_guard, p_pix, p_fs, p_ls;
    logic [1:0]  p_ch0, p_ch1, p_ch2;
    logic [11:0] p_h, p_v;

    tmds_period_scheduler dut (
        .clk(clk), .Reset_n(rst_n), .en(en), .de(d_de),
        .ch0_ctrl(d_ch0), .ch1_ctrl(d_ch1), .ch2_ctrl(d_ch2), .guard(d_guard),
        .pix_req(d_pix), .hcount(d_h), .vcount(d_v),
        .frame_start(d_fs), .line_start(d_ls)
    );

    tmds_period_scheduler #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(12),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .HDMI_MODE(1)
    ) dut_s (
        .clk(clk), .Reset_n(rst_n), .en(en), .de(s_de),
        .ch0_ctrl(s_ch0), .ch1_ctrl(s_ch1), .ch2_ctrl(s_ch2), .guard(s_guard),
        .pix_req(s_pix), .hcount(s_h), .vcount(s_v),
        .frame_start(s_fs), .line_start(s_ls)
    );

    tmds_period_scheduler #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(12),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .HDMI_MODE(0)
    ) dut_p (
        .clk(clk), .Reset_n(rst_n), .en(en), .de(p_de),
        .ch0_ctrl(p_ch0), .ch1_ctrl(p_ch1), .ch2_ctrl(p_ch2), .guard(p_guard),
        .pix_req(p_pix), .hcount(p_h), .vcount(p_v),
        .frame_start(p_fs), .line_start(p_ls)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk the small instance to (h,v), bounded.
    task automatic goto_s(input int h, input int v);
        int n;
        n = 0;
        while (!(s_h == 12'(h) && s_v == 12'(v)) && n < 2000) begin
            step();
            n++;
        end
        chk("goto_timeout", (n < 2000) ? 1 : 0, 1);
    endtask

    initial begin
        int pos_bad, de_cnt, de_bad, hs_lo, hs_bad, grd_cnt, grd_bad, pre_bad;
        int vs_lo, pre_s, ch2_nz, l5, l12_pre, l12_grd, p_grd, p_ctl;
        int fs_cnt, ls_cnt, ls_bad, pix_cnt, pair_bad, h, v;
        logic prev_pix;

        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_de",    d_de, 0);
        chk("rst_guard", d_guard, 0);
        chk("rst_pix",   d_pix, 0);
        chk("rst_fs",    d_fs, 0);
        chk("rst_ls",    d_ls, 0);
        chk("rst_h",     d_h, 0);
        chk("rst_v",     d_v, 0);
        chk("rst_ch0",   d_ch0, 3);
        chk("rst_ch1",   d_ch1, 0);
        chk("rst_ch2",   d_ch2, 0);

        rst_n = 1'b1;
        step();
        chk("first_h",  d_h, 0);
        chk("first_v",  d_v, 0);
        chk("first_de", d_de, 1);
        chk("first_fs", d_fs, 1);
        chk("first_ls", d_ls, 1);

        // Line 0 of the 640x480 raster.
        pos_bad = 0; de_cnt = 0; de_bad = 0; hs_lo = 0; hs_bad = 0;
        grd_cnt = 0; grd_bad = 0; pre_bad = 0;
        for (int k = 0; k < 800; k++) begin
            if (d_h != 12'(k) || d_v != 12'd0) pos_bad++;
            if (d_de) begin
                de_cnt++;
                if (k >= 640) de_bad++;
            end
            if (!d_de && !d_ch0[0]) begin
                hs_lo++;
                if (k < 656 || k > 751) hs_bad++;
            end
            if (d_guard) begin
                grd_cnt++;
                if (k < 798) grd_bad++;
            end
            if (k >= 790 && k <= 797 &&
                !(d_ch1 == 2'b01 && d_ch2 == 2'b00 && !d_de && !d_guard)) pre_bad++;
            if (k >= 798 && !(d_ch1 == 2'b01 && !d_de)) pre_bad++;
            if (k < 790 && d_ch1 != 2'b00) pre_bad++;
            step();
        end
        chk("l0_pos",     pos_bad, 0);
        chk("l0_de_cnt",  de_cnt, 640);
        chk("l0_de_late", de_bad, 0);
        chk("l0_hs_lo",   hs_lo, 96);
        chk("l0_hs_pos",  hs_bad, 0);
        chk("l0_grd_cnt", grd_cnt, 2);
        chk("l0_grd_pos", grd_bad, 0);
        chk("l0_pre",     pre_bad, 0);
        chk("l1_h",  d_h, 0);
        chk("l1_v",  d_v, 1);
        chk("l1_ls", d_ls, 1);
        chk("l1_fs", d_fs, 0);

        // Full small frame, both HDMI and DVI instances.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        pos_bad = 0; de_bad = 0; hs_lo = 0; vs_lo = 0; grd_cnt = 0; pre_s = 0;
        ch2_nz = 0; l5 = 0; l12_pre = 0; l12_grd = 0; p_grd = 0; p_ctl = 0;
        fs_cnt = 0; ls_cnt = 0; ls_bad = 0; pix_cnt = 0; pair_bad = 0; pre_bad = 0;
        prev_pix = 1'b0;
        for (int k = 0; k <= 494; k++) begin
            h = k % 38;
            v = (k / 38) % 13;
            if (k >= 1 && s_de != prev_pix) pair_bad++;
            prev_pix = s_pix;
            if (k < 494) begin
                pix_cnt += int'(s_pix);
                if (s_h != 12'(h) || s_v != 12'(v)) pos_bad++;
                if (p_h != 12'(h) || p_v != 12'(v)) pos_bad++;
                if (s_de != (h < 16 && v < 6)) de_bad++;
                if (p_de != (h < 16 && v < 6)) de_bad++;
                if (!s_de && !s_ch0[0]) hs_lo++;
                if (!s_de && !s_ch0[1]) vs_lo++;
                grd_cnt += int'(s_guard);
                if (s_ch1 == 2'b01) pre_s++;
                if (s_ch2 != 2'b00) ch2_nz++;
                if (v == 5 && (s_guard || s_ch1 != 2'b00)) l5++;
                if (v == 12 && s_ch1 == 2'b01 && !s_guard) l12_pre++;
                if (v == 12) l12_grd += int'(s_guard);
                if (v == 0 && h >= 28 && h <= 35 && !(s_ch1 == 2'b01 && !s_guard)) pre_bad++;
                p_grd += int'(p_guard);
                if (p_ch1 != 2'b00 || p_ch2 != 2'b00) p_ctl++;
                fs_cnt += int'(s_fs);
                ls_cnt += int'(s_ls);
                if (s_ls != (h == 0)) ls_bad++;
                step();
            end
        end
        chk("fr_pos",      pos_bad, 0);
        chk("fr_de",       de_bad, 0);
        chk("fr_pix_cnt",  pix_cnt, 96);
        chk("fr_pix_pair", pair_bad, 0);
        chk("fr_hs_lo",    hs_lo, 78);
        chk("fr_vs_lo",    vs_lo, 76);
        chk("fr_grd_cnt",  grd_cnt, 12);
        chk("fr_ch1_cnt",  pre_s, 60);
        chk("fr_ch2_nz",   ch2_nz, 0);
        chk("fr_l0_pre",   pre_bad, 0);
        chk("fr_last_act", l5, 0);
        chk("fr_l12_pre",  l12_pre, 8);
        chk("fr_l12_grd",  l12_grd, 2);
        chk("dvi_guard",   p_grd, 0);
        chk("dvi_ctl",     p_ctl, 0);
        chk("fr_fs_cnt",   fs_cnt, 1);
        chk("fr_ls_cnt",   ls_cnt, 13);
        chk("fr_ls_pos",   ls_bad, 0);

        // Async reset in the middle of a preamble.
        goto_s(30, 3);
        chk("mid_pre_ch1", s_ch1, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_de",  s_de, 0);
        chk("ar_h",   s_h, 0);
        chk("ar_v",   s_v, 0);
        chk("ar_ch0", s_ch0, 3);
        chk("ar_ch1", s_ch1, 0);
        chk("ar_pix", s_pix, 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("ar_rs_h",  s_h, 0);
        chk("ar_rs_v",  s_v, 0);
        chk("ar_rs_fs", s_fs, 1);
        chk("ar_rs_de", s_de, 1);

        // Synchronous en drop at the same point.
        goto_s(30, 3);
        en = 1'b0;
        #1;
        chk("en_hold_h",   s_h, 30);
        chk("en_hold_ch1", s_ch1, 1);
        step();
        chk("en_de",    s_de, 0);
        chk("en_h",     s_h, 0);
        chk("en_v",     s_v, 0);
        chk("en_ch0",   s_ch0, 3);
        chk("en_ch1",   s_ch1, 0);
        chk("en_guard", s_guard, 0);
        chk("en_fs",    s_fs, 0);
        @(negedge clk) en = 1'b1;
        step();
        chk("en_rs_h",  s_h, 0);
        chk("en_rs_fs", s_fs, 1);
        chk("en_rs_ls", s_ls, 1);
        chk("en_rs_de", s_de, 1);
        chk("en_rs_pix", s_pix, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
